// File: rtl/clkdiv_cfg_pkg.sv
// Shared types and defaults for the divider-configuration arbiter.
package clkdiv_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_TC = 2'd1,
      ST_SETTLE  = 2'd2,
      ST_ACK     = 2'd3
   } state_e;

   localparam int unsigned SETTLE_DEFAULT = 2;

   // Counter must reach both the tc timeout (DIV_MAX) and the settle length.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches upward starting at the index after ptr_i.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   int unsigned pos;
   logic        found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         pos = (32'(ptr_i) + k) % N;
         if (!found && req_i[pos]) begin
            found      = 1'b1;
            gnt_o[pos] = 1'b1;
            idx_o      = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/clkdiv_cfg_arb.sv
// Arbitrates divisor-change requests and applies the winner's divisor
// at a divider terminal-count boundary, then acknowledges after settling.
module clkdiv_cfg_arb
   import clkdiv_cfg_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned DIV_MAX  = 8,
   parameter int unsigned DIV_INIT = 0,
   parameter int unsigned SETTLE   = SETTLE_DEFAULT
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_REQ-1:0]                    req,
   input  logic [N_REQ*$clog2(DIV_MAX)-1:0]    req_div,
   input  logic                                div_tc,
   output logic [$clog2(DIV_MAX)-1:0]          div,
   output logic [N_REQ-1:0]                    ack,
   output logic                                busy,
   output logic [$clog2(N_REQ)-1:0]            grant_idx
);

   localparam int unsigned DW = $clog2(DIV_MAX);
   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned CW = cnt_width(DIV_MAX, SETTLE);

   state_e        state_q, state_d;
   logic [DW-1:0] div_q,   div_d;
   logic [DW-1:0] pend_q,  pend_d;
   logic [IW-1:0] gidx_q,  gidx_d;
   logic [IW-1:0] ptr_q,   ptr_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   logic [N_REQ-1:0] arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic [DW-1:0]    sel_div;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr_arbiter (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   // One-hot AND-OR select of the winner's requested divisor.
   always_comb begin
      sel_div = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) sel_div = sel_div | req_div[i*DW +: DW];
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      pend_d  = pend_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               pend_d  = sel_div;
               gidx_d  = arb_idx;
               cnt_d   = '0;
               state_d = ST_WAIT_TC;
            end
         end
         ST_WAIT_TC: begin
            // Bypass (div 0) never produces tc; the timeout guards a stuck divider.
            if (pend_q == div_q) begin
               state_d = ST_ACK;
            end else if ((div_q == '0) || div_tc || (cnt_q == CW'(DIV_MAX))) begin
               div_d   = pend_q;
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_ACK: begin
            ptr_d   = gidx_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         div_q   <= DW'(DIV_INIT);
         pend_q  <= '0;
         gidx_q  <= '0;
         ptr_q   <= IW'(N_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         pend_q  <= pend_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      ack = '0;
      if (state_q == ST_ACK) ack[gidx_q] = 1'b1;
   end

   assign div       = div_q;
   assign busy      = (state_q != ST_IDLE);
   assign grant_idx = gidx_q;

endmodule

// File: tb/tb_clkdiv_cfg_arb.sv
// Directed self-checking bench for clkdiv_cfg_arb (N_REQ=4, DIV_MAX=8, SETTLE=2).
module tb_clkdiv_cfg_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned DM = 8;
   localparam int unsigned DW = 3;
   localparam int unsigned IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_div;
   logic            div_tc;
   logic [DW-1:0]   div;
   logic [N-1:0]    ack;
   logic            busy;
   logic [IW-1:0]   grant_idx;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   clkdiv_cfg_arb #(
      .N_REQ    (N),
      .DIV_MAX  (DM),
      .DIV_INIT (0),
      .SETTLE   (2)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_div   (req_div),
      .div_tc    (div_tc),
      .div       (div),
      .ack       (ack),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst     = 1'b1;
      req     = '0;
      req_div = '0;
      div_tc  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Loads a divisor through requester 3 with tc available every cycle.
   task automatic set_div(input logic [DW-1:0] v);
      int c;
      req_div[3*DW +: DW] = v;
      req[3] = 1'b1;
      div_tc = 1'b1;
      c = 0;
      while (ack[3] !== 1'b1 && c < 30) begin
         tick();
         c++;
      end
      check_eq("set_div_ack", 32'(ack[3]), 32'd1);
      req[3] = 1'b0;
      div_tc = 1'b0;
      tick();
      check_eq("set_div_val", 32'(div), 32'(v));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_idx [5] = '{0, 1, 2, 3, 0};
      int exp_div [5] = '{1, 2, 3, 4, 1};
      int n_ack;

      // Reset state and bypass load.
      reset_dut();
      check_eq("rst_div",  32'(div),       32'd0);
      check_eq("rst_busy", 32'(busy),      32'd0);
      check_eq("rst_ack",  32'(ack),       32'd0);
      check_eq("rst_gidx", 32'(grant_idx), 32'd0);
      req_div[1*DW +: DW] = 3'd3;
      req[1] = 1'b1;
      tick();
      check_eq("byp_busy", 32'(busy),      32'd1);
      check_eq("byp_gidx", 32'(grant_idx), 32'd1);
      check_eq("byp_div0", 32'(div),       32'd0);
      tick();
      check_eq("byp_div",  32'(div), 32'd3);
      check_eq("byp_ack0", 32'(ack), 32'd0);
      tick();
      check_eq("byp_ack1", 32'(ack), 32'd0);
      tick();
      check_eq("byp_ack",  32'(ack),  32'b0010);
      check_eq("byp_busyA", 32'(busy), 32'd1);
      req[1] = 1'b0;
      tick();
      check_eq("byp_idle", 32'(busy), 32'd0);
      check_eq("byp_ackE", 32'(ack),  32'd0);

      // Change applied exactly on the tc edge; req_div edits after grant ignored.
      reset_dut();
      set_div(3'd4);
      req_div[0 +: DW] = 3'd2;
      req[0] = 1'b1;
      tick();
      check_eq("tc_gidx", 32'(grant_idx), 32'd0);
      req_div[0 +: DW] = 3'd7;
      tick();
      check_eq("tc_hold1", 32'(div), 32'd4);
      tick();
      check_eq("tc_hold2", 32'(div), 32'd4);
      div_tc = 1'b1;
      tick();
      check_eq("tc_div", 32'(div), 32'd2);
      div_tc = 1'b0;
      tick();
      check_eq("tc_ack0", 32'(ack), 32'd0);
      tick();
      check_eq("tc_ack", 32'(ack), 32'b0001);
      req[0] = 1'b0;
      tick();
      check_eq("tc_idle", 32'(busy), 32'd0);
      check_eq("tc_final", 32'(div), 32'd2);

      // All requesters held: fair rotation 0,1,2,3,0.
      reset_dut();
      req_div = {3'd4, 3'd3, 3'd2, 3'd1};
      div_tc  = 1'b1;
      req     = 4'b1111;
      n_ack   = 0;
      for (int c = 0; c < 80 && n_ack < 5; c++) begin
         tick();
         check_eq("rr_onehot", 32'($onehot0(ack)), 32'd1);
         if (ack != '0) begin
            check_eq("rr_ack",  32'(ack),       32'd1 << exp_idx[n_ack]);
            check_eq("rr_gidx", 32'(grant_idx), 32'(exp_idx[n_ack]));
            check_eq("rr_div",  32'(div),       32'(exp_div[n_ack]));
            n_ack++;
         end
      end
      check_eq("rr_count", 32'(n_ack), 32'd5);
      req    = '0;
      div_tc = 1'b0;
      tick();
      tick();

      // No tc ever: timeout after DIV_MAX+1 cycles in WAIT_TC.
      reset_dut();
      set_div(3'd5);
      req_div[0 +: DW] = 3'd2;
      req[0] = 1'b1;
      tick();
      for (int i = 1; i <= int'(DM); i++) begin
         tick();
         check_eq("to_hold", 32'(div), 32'd5);
      end
      tick();
      check_eq("to_div", 32'(div), 32'd2);
      tick();
      check_eq("to_ack0", 32'(ack), 32'd0);
      tick();
      check_eq("to_ack", 32'(ack), 32'b0001);
      req[0] = 1'b0;
      tick();

      // Equal divisor: ack without change; then reset during SETTLE.
      reset_dut();
      set_div(3'd3);
      req_div[1*DW +: DW] = 3'd3;
      req[1] = 1'b1;
      tick();
      check_eq("eq_ack0", 32'(ack),  32'd0);
      check_eq("eq_busy", 32'(busy), 32'd1);
      tick();
      check_eq("eq_ack", 32'(ack), 32'b0010);
      check_eq("eq_div", 32'(div), 32'd3);
      req[1] = 1'b0;
      tick();
      check_eq("eq_idle", 32'(busy), 32'd0);
      req_div[2*DW +: DW] = 3'd6;
      req[2] = 1'b1;
      div_tc = 1'b1;
      tick();
      check_eq("ab_gidx", 32'(grant_idx), 32'd2);
      tick();
      check_eq("ab_div", 32'(div), 32'd6);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check_eq("ab_rdiv",  32'(div),       32'd0);
      check_eq("ab_rack",  32'(ack),       32'd0);
      check_eq("ab_rbusy", 32'(busy),      32'd0);
      check_eq("ab_rgidx", 32'(grant_idx), 32'd0);
      req    = '0;
      div_tc = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("ab_noack", 32'(ack), 32'd0);
      end
      check_eq("ab_div_end", 32'(div), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
